// File: rtl/pdm_cic_decimator_if.sv
//==============================================================================
// Module : pdm_cic_decimator_if
// Purpose: Bundles the PDM input pair and the PCM output bus of
//          pdm_cic_decimator so source and sink hook up through one port.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
// Signals:
//   sdi      1   PDM bit stream (source -> decimator)
//   ock      1   PDM oversample clock, carried as data (source -> decimator)
//   dout     32  mono/left PCM sample, offset binary (decimator -> sink)
//   dout_r   32  right PCM sample, offset binary (decimator -> sink)
//   dout_vld 1   one-clk strobe when dout/dout_r update (decimator -> sink)
// Modports:
//   master - PDM source / PCM consumer side
//   slave  - decimator side
//==============================================================================
`default_nettype none

interface pdm_cic_decimator_if;
   logic        sdi;
   logic        ock;
   logic [31:0] dout;
   logic [31:0] dout_r;
   logic        dout_vld;

   modport master (
      output sdi,
      output ock,
      input  dout,
      input  dout_r,
      input  dout_vld
   );

   modport slave (
      input  sdi,
      input  ock,
      output dout,
      output dout_r,
      output dout_vld
   );
endinterface

`default_nettype wire

// File: rtl/pdm_cic_decimator.sv
//==============================================================================
// Module : pdm_cic_decimator
// Purpose: N-stage CIC decimator (factor R) turning a 1-bit PDM stream into
//          32-bit offset-binary PCM (0x80000000 = zero) with a valid strobe.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
// Ports:
//   clk   in   system clock, posedge
//   rstn  in   asynchronous active-low reset
//   bus   slave modport of pdm_cic_decimator_if (sdi, ock in; dout, dout_r,
//         dout_vld out)
// Parameters:
//   N  number of integrator/comb stages (1..6)
//   R  decimation factor, power of 2 (>= 2), N*log2(R) <= 31
// Build option:
//   PDM_CIC_STEREO_EN  defined   -> second chain on ock falling edges drives
//                                   dout_r
//                      undefined -> dout_r tied to 0x80000000
//==============================================================================
`default_nettype none

module pdm_cic_decimator #(
   parameter int N = 4,
   parameter int R = 64
) (
   input wire                clk,
   input wire                rstn,
   pdm_cic_decimator_if.slave bus
);

   localparam int LOG2R = $clog2(R);
   localparam int NL    = N * LOG2R;
   localparam int W     = 1 + NL;
   // One guard bit above W: with +/-1 inputs the window sum reaches exactly
   // +/-R^N, and both ends must stay distinct to saturate to opposite rails.
   localparam int WD    = W + 1;
   localparam int SH    = 31 - NL;
   localparam int SW    = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COMB  = 2'd1,
      S_SCALE = 2'd2
   } state_t;

   // Offset-binary conversion with saturation to the 32-bit rails.
   function automatic logic [31:0] f_scale(input logic signed [WD-1:0] v);
      logic signed [32:0] s;
      logic signed [33:0] sum;
      s   = 33'(v) <<< SH;
      sum = 34'(s) + 34'sd2147483648;
      if (sum < 0)
         return 32'h0000_0000;
      else if (sum > 34'sd4294967295)
         return 32'hFFFF_FFFF;
      else
         return sum[31:0];
   endfunction

   // ---------------------------------------------------------------- capture
   logic r_ock_s1, r_ock_s2, r_ock_d;
   logic r_sdi_s1, r_sdi_s2;
   logic r_rise, r_bit;
   logic w_rise;

   assign w_rise = r_ock_s2 & ~r_ock_d;

`ifdef PDM_CIC_STEREO_EN
   logic r_fall;
   logic w_fall;
   assign w_fall = ~r_ock_s2 & r_ock_d;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ock_s1 <= 1'b0;
         r_ock_s2 <= 1'b0;
         r_ock_d  <= 1'b0;
         r_sdi_s1 <= 1'b0;
         r_sdi_s2 <= 1'b0;
         r_rise   <= 1'b0;
         r_bit    <= 1'b0;
`ifdef PDM_CIC_STEREO_EN
         r_fall   <= 1'b0;
`endif
      end else begin
         r_ock_s1 <= bus.ock;
         r_ock_s2 <= r_ock_s1;
         r_ock_d  <= r_ock_s2;
         r_sdi_s1 <= bus.sdi;
         r_sdi_s2 <= r_sdi_s1;
         // sdi travels with ock so r_bit is the value seen at the edge
         r_rise   <= w_rise;
         r_bit    <= r_sdi_s2;
`ifdef PDM_CIC_STEREO_EN
         r_fall   <= w_fall;
`endif
      end
   end

   // sdi=1 -> +1, sdi=0 -> -1
   logic signed [WD-1:0] w_x;
   assign w_x = {{(WD-1){~r_bit}}, 1'b1};

   // ------------------------------------------------- integrators / counter
   logic signed [WD-1:0] r_integ [N];
   logic [LOG2R-1:0]     r_cnt;
   logic                 r_tick;

`ifdef PDM_CIC_STEREO_EN
   logic signed [WD-1:0] r_integ_r [N];
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < N; k++) begin
            r_integ[k] <= '0;
`ifdef PDM_CIC_STEREO_EN
            r_integ_r[k] <= '0;
`endif
         end
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= r_rise & (&r_cnt);
         if (r_rise) begin
            r_cnt      <= r_cnt + 1'b1;
            // Every stage adds the previous stage's old value (cascade).
            r_integ[0] <= r_integ[0] + w_x;
            for (int k = 1; k < N; k++)
               r_integ[k] <= r_integ[k] + r_integ[k-1];
         end
`ifdef PDM_CIC_STEREO_EN
         if (r_fall) begin
            r_integ_r[0] <= r_integ_r[0] + w_x;
            for (int k = 1; k < N; k++)
               r_integ_r[k] <= r_integ_r[k] + r_integ_r[k-1];
         end
`endif
      end
   end

   // ------------------------------------------------------ comb / scale FSM
   state_t               r_state;
   logic [SW-1:0]        r_stage;
   logic signed [WD-1:0] r_comb_x;
   logic signed [WD-1:0] r_comb_dly [N];
   logic [31:0]          r_dout;
   logic                 r_dout_vld;

`ifdef PDM_CIC_STEREO_EN
   logic signed [WD-1:0] r_comb_xr;
   logic signed [WD-1:0] r_comb_dly_r [N];
   logic [31:0]          r_dout_r;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= S_IDLE;
         r_stage    <= '0;
         r_comb_x   <= '0;
         r_dout     <= 32'h8000_0000;
         r_dout_vld <= 1'b0;
         for (int k = 0; k < N; k++)
            r_comb_dly[k] <= '0;
`ifdef PDM_CIC_STEREO_EN
         r_comb_xr  <= '0;
         r_dout_r   <= 32'h8000_0000;
         for (int k = 0; k < N; k++)
            r_comb_dly_r[k] <= '0;
`endif
      end else begin
         r_dout_vld <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_tick) begin
                  r_comb_x  <= r_integ[N-1];
`ifdef PDM_CIC_STEREO_EN
                  r_comb_xr <= r_integ_r[N-1];
`endif
                  r_stage   <= '0;
                  r_state   <= S_COMB;
               end
            end
            S_COMB: begin
               // One comb stage per clk, reusing a single subtractor.
               r_comb_x <= r_comb_x - r_comb_dly[r_stage];
`ifdef PDM_CIC_STEREO_EN
               r_comb_xr <= r_comb_xr - r_comb_dly_r[r_stage];
`endif
               for (int k = 0; k < N; k++) begin
                  if (SW'(k) == r_stage) begin
                     r_comb_dly[k] <= r_comb_x;
`ifdef PDM_CIC_STEREO_EN
                     r_comb_dly_r[k] <= r_comb_xr;
`endif
                  end
               end
               if (r_stage == SW'(N - 1))
                  r_state <= S_SCALE;
               else
                  r_stage <= r_stage + 1'b1;
            end
            S_SCALE: begin
               r_dout     <= f_scale(r_comb_x);
`ifdef PDM_CIC_STEREO_EN
               r_dout_r   <= f_scale(r_comb_xr);
`endif
               r_dout_vld <= 1'b1;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.dout     = r_dout;
   assign bus.dout_vld = r_dout_vld;
`ifdef PDM_CIC_STEREO_EN
   assign bus.dout_r   = r_dout_r;
`else
   assign bus.dout_r   = 32'h8000_0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pdm_cic_decimator.sv
//==============================================================================
// Module : tb_pdm_cic_decimator
// Purpose: Self-checking bench for pdm_cic_decimator (N=4, R=64). Stimulus
//          queues expected PCM words; a monitor pops them on each dout_vld.
// Revision: 1.0 - initial release
// Build option: PDM_CIC_STEREO_EN selects the expected dout_r values.
//==============================================================================
`timescale 1ns/100ps
`default_nettype none

module tb_pdm_cic_decimator;

   localparam int N   = 4;
   localparam int R   = 64;
   localparam int OCK = 6;   // clk per ock period (3 high, 3 low)

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   pdm_cic_decimator_if u_if ();

   pdm_cic_decimator #(.N(N), .R(R)) u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (u_if.slave)
   );

   always #33.3 clk = ~clk;

   typedef struct {
      bit          chk;
      logic [31:0] exp_l;
      logic [31:0] exp_r;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] f_r(input logic [31:0] v);
`ifdef PDM_CIC_STEREO_EN
      return v;
`else
      return 32'h8000_0000;
`endif
   endfunction

   // ---------------------------------------------------------------- monitor
   int          last_vld   = -1;
   logic [31:0] last_dout  = 32'h8000_0000;
   logic        prev_rstn  = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (!rstn) last_vld = -1;
      if (rstn && u_if.dout_vld) begin
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_vld: pulse at cyc %0d dout=%h, required no pulse", cyc, u_if.dout);
         end else begin
            e = q.pop_front();
            if (e.chk) begin
               checks++;
               if (u_if.dout !== e.exp_l) begin
                  errors++;
                  $display("FAIL dout: got %h required %h", u_if.dout, e.exp_l);
               end
               checks++;
               if (u_if.dout_r !== e.exp_r) begin
                  errors++;
                  $display("FAIL dout_r: got %h required %h", u_if.dout_r, e.exp_r);
               end
            end
         end
         if (last_vld >= 0) begin
            checks++;
            if (cyc - last_vld != R * OCK) begin
               errors++;
               $display("FAIL vld_spacing: got %0d clk required %0d clk", cyc - last_vld, R * OCK);
            end
         end
         last_vld = cyc;
      end else if (rstn && prev_rstn) begin
         checks++;
         if (u_if.dout !== last_dout) begin
            errors++;
            $display("FAIL dout_hold: got %h required %h", u_if.dout, last_dout);
         end
      end
      last_dout = u_if.dout;
      prev_rstn = rstn;
   end

   // -------------------------------------------------------------- stimulus
   task automatic rise_cycle(input bit sr, input bit sf);
      @(negedge clk);
      u_if.ock = 1'b1;
      u_if.sdi = sr;
      repeat (3) @(negedge clk);
      u_if.ock = 1'b0;
      u_if.sdi = sf;
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      u_if.ock = 1'b0;
      u_if.sdi = 1'b0;
      #5 rstn = 1'b0;
      #1;
      checks++;
      if (u_if.dout !== 32'h8000_0000 || u_if.dout_vld !== 1'b0 || u_if.dout_r !== 32'h8000_0000) begin
         errors++;
         $display("FAIL reset_state: got dout=%h dout_r=%h vld=%b required 80000000/80000000/0",
                  u_if.dout, u_if.dout_r, u_if.dout_vld);
      end
      repeat (3) @(negedge clk);
      rstn = 1'b1;
   endtask

   function automatic bit pat(input int mode, input int i);
      case (mode)
         0:       return 1'b1;
         1:       return 1'b0;
         2:       return (i % 2) == 0;
         default: return (i % 4) != 3;
      endcase
   endfunction

   task automatic run_test(input string name, input int mode, input bit inv_fall,
                           input logic [31:0] exp_l, input logic [31:0] exp_r);
      exp_t e;
      bit   b;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         e.chk   = (k >= N);
         e.exp_l = exp_l;
         e.exp_r = f_r(exp_r);
         q.push_back(e);
      end
      for (int i = 0; i < 6 * R; i++) begin
         b = pat(mode, i);
         rise_cycle(b, inv_fall ? ~b : b);
      end
      repeat (20) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL %s_count: got %0d outputs missing, required 0", name, q.size());
      end
   endtask

   initial begin
      exp_t e;
      int   lat;
      bit   got;
      u_if.ock = 1'b0;
      u_if.sdi = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      run_test("ones", 0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // Reset mid-frame: counter sits at 30, dout currently full scale.
      for (int i = 0; i < 30; i++) rise_cycle(1'b1, 1'b1);
      @(negedge clk);
      #5 rstn = 1'b0;
      #1;
      checks++;
      if (u_if.dout !== 32'h8000_0000 || u_if.dout_vld !== 1'b0) begin
         errors++;
         $display("FAIL midframe_reset: got dout=%h vld=%b required 80000000/0", u_if.dout, u_if.dout_vld);
      end
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      // 63 fresh rises must produce nothing; the monitor flags any pulse.
      for (int i = 0; i < R - 1; i++) rise_cycle(1'b1, 1'b1);
      e.chk = 1'b0; e.exp_l = '0; e.exp_r = '0;
      q.push_back(e);
      @(negedge clk);
      u_if.ock = 1'b1;
      u_if.sdi = 1'b1;
      @(posedge clk);   // first edge sampling ock high on the 64th rise
      lat = 0;
      got = 1'b0;
      for (int c = 1; c <= 40 && !got; c++) begin
         @(posedge clk);
         #1;
         if (u_if.dout_vld) begin
            got = 1'b1;
            lat = c;
         end
      end
      checks++;
      if (!got || lat != N + 5) begin
         errors++;
         $display("FAIL latency: got %0d clk (seen=%0d) required %0d clk", lat, got, N + 5);
      end
      @(negedge clk);
      u_if.ock = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL latency_count: got %0d outputs missing, required 0", q.size());
      end

      run_test("zeros", 1, 1'b0, 32'h0000_0000, 32'h0000_0000);
      run_test("alt",   2, 1'b0, 32'h8000_0000, 32'h8000_0000);
      run_test("d75",   3, 1'b0, 32'hC000_0000, 32'hC000_0000);
      run_test("stereo",0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);

      // ock stopped: no pulses, dout held (monitor checks hold each clk).
      repeat (600) @(negedge clk);
      #1;
      checks++;
      if (u_if.dout !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL stopped_hold: got %h required ffffffff", u_if.dout);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
